pc_sequencer: RTL and testbench

- Multi-cycle fetch/execute sequencer for the non-pipelined LEGv8 core.
- Owns the PC and runs the instruction-memory fetch handshake.
- Holds each instruction for the datapath until the datapath signals completion, then updates the PC from the 2-bit branch-source selection produced by the branch-condition logic: sequential, PC-relative, register (ALU), or no-increment/halt.

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer_if.sv | 37 +++
 rtl/pc_sequencer_pc_next_calc.sv | 40 ++++
 rtl/pc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
// Shared constants for the LEGv8 fetch/execute sequencer:
//   - branch-source selection codes produced by the branch-condition logic
//   - the 2-bit sequencer state encoding
//   - a saturating increment helper used by the optional statistics counters
//     (enabled with the PC_SEQ_STATS_EN macro in pc_sequencer)
package pc_sequencer_pkg;

  // Branch-source selection codes
  localparam logic [1:0] BRANCH_SRC_SEQ  = 2'b00;  // PC + 4
  localparam logic [1:0] BRANCH_SRC_REL  = 2'b01;  // PC + branch_offset
  localparam logic [1:0] BRANCH_SRC_ALU  = 2'b10;  // register target (BR)
  localparam logic [1:0] BRANCH_SRC_HOLD = 2'b11;  // no increment, halt

  // Sequencer states
  typedef enum logic [1:0] {
    PCSEQ_IDLE  = 2'b00,
    PCSEQ_FETCH = 2'b01,
    PCSEQ_EXEC  = 2'b10,
    PCSEQ_HALT  = 2'b11
  } pcseq_state_e;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == STAT_MAX) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the instruction-memory fetch handshake and the datapath execute
// handshake of the sequencer.
//   imem_req / imem_addr      : fetch request and address (sequencer drives)
//   imem_ack / imem_rdata     : fetch data valid and instruction (memory drives)
//   instr / instr_valid       : latched instruction for the datapath
//   exec_done                 : datapath finished the current instruction
//   branch_src / branch_offset / alu_result : next-PC selection inputs
// Modports: master = sequencer side, slave = memory/datapath side.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               exec_done;
  logic [1:0]         branch_src;
  logic [ADDR_W-1:0]  branch_offset;
  logic [ADDR_W-1:0]  alu_result;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, exec_done, branch_src, branch_offset, alu_result
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, exec_done, branch_src, branch_offset, alu_result
  );

endinterface

// File: rtl/pc_sequencer_pc_next_calc.sv
// pc_next_calc
// Combinational next-PC selection and register-target alignment check.
//   pc            : current PC
//   branch_src    : 00 PC+4, 01 PC+offset, 10 ALU target, 11 hold
//   branch_offset : two's-complement byte offset (already shifted by 2)
//   alu_result    : register branch target
//   next_pc       : candidate next PC (all sums wrap modulo 2^ADDR_W)
//   misaligned    : ALU target selected and not word aligned
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        branch_src,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] alu_result,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  localparam logic [ADDR_W-1:0] INSTR_BYTES = ADDR_W'(4);

  // Plain unsigned addition gives the two's-complement result for negative
  // offsets, and dropping the carry gives the silent wrap.
  always_comb begin
    next_pc    = pc;
    misaligned = 1'b0;
    case (branch_src)
      BRANCH_SRC_SEQ:  next_pc = pc + INSTR_BYTES;
      BRANCH_SRC_REL:  next_pc = pc + branch_offset;
      BRANCH_SRC_ALU: begin
        next_pc    = alu_result;
        misaligned = (alu_result[1:0] != 2'b00);
      end
      default:         next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Multi-cycle fetch/execute sequencer for the non-pipelined LEGv8 core.
// Owns the PC, runs the instruction-memory fetch handshake, holds each
// instruction for the datapath until exec_done, then updates the PC from
// the branch-source selection.
// Ports:
//   clk, reset    : clock (rising edge), asynchronous active-high reset
//   start         : one-cycle pulse that leaves IDLE
//   bus (master)  : fetch and execute handshakes, see pc_sequencer_if
//   pc            : current PC (imem_addr is wired to it)
//   halted        : core stopped (hold selection or fault)
//   fault         : misaligned register-branch target
//   retired_count, taken_count : only when PC_SEQ_STATS_EN is defined;
//                   saturating counts of retired instructions and of
//                   non-sequential PC loads
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  pc_sequencer_if.master     bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               fault
`ifdef PC_SEQ_STATS_EN
  ,
  output logic [31:0]        retired_count,
  output logic [31:0]        taken_count
`endif
);

  pcseq_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               imem_req_q, imem_req_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  logic [ADDR_W-1:0]  next_pc;
  logic               misaligned;

`ifdef PC_SEQ_STATS_EN
  logic [31:0]        retired_q, retired_d;
  logic [31:0]        taken_q, taken_d;
`endif

  pc_next_calc #(
    .ADDR_W (ADDR_W)
  ) u_next_calc (
    .pc            (pc_q),
    .branch_src    (bus.branch_src),
    .branch_offset (bus.branch_offset),
    .alu_result    (bus.alu_result),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  // Next-state logic. imem_req is registered, so it is raised on the same
  // edge that enters FETCH and dropped on the edge that accepts the ack.
  // Inputs outside their state's window are simply never looked at.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    halted_d      = halted_q;
    fault_d       = fault_q;
`ifdef PC_SEQ_STATS_EN
    retired_d     = retired_q;
    taken_d       = taken_q;
`endif

    case (state_q)
      PCSEQ_IDLE: begin
        if (start) begin
          state_d    = PCSEQ_FETCH;
          imem_req_d = 1'b1;
        end
      end

      PCSEQ_FETCH: begin
        if (bus.imem_ack) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = PCSEQ_EXEC;
        end
      end

      PCSEQ_EXEC: begin
        if (bus.exec_done) begin
          instr_valid_d = 1'b0;
`ifdef PC_SEQ_STATS_EN
          retired_d     = sat_inc(retired_q);
`endif
          if (bus.branch_src == BRANCH_SRC_HOLD) begin
            halted_d = 1'b1;
            state_d  = PCSEQ_HALT;
          end else if (misaligned) begin
            // PC is left pointing at the branch that faulted.
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = PCSEQ_HALT;
          end else begin
            pc_d       = next_pc;
            imem_req_d = 1'b1;
            state_d    = PCSEQ_FETCH;
`ifdef PC_SEQ_STATS_EN
            if (bus.branch_src != BRANCH_SRC_SEQ) begin
              taken_d = sat_inc(taken_q);
            end
`endif
          end
        end
      end

      default: begin
        // HALT is terminal until reset.
        state_d = PCSEQ_HALT;
      end
    endcase
  end

  // All state and registered outputs; reset clears them asynchronously so
  // imem_req and instr_valid drop without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PCSEQ_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
`ifdef PC_SEQ_STATS_EN
      retired_q     <= '0;
      taken_q       <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
`ifdef PC_SEQ_STATS_EN
      retired_q     <= retired_d;
      taken_q       <= taken_d;
`endif
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign fault           = fault_q;
`ifdef PC_SEQ_STATS_EN
  assign retired_count   = retired_q;
  assign taken_count     = taken_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Scoreboard bench for pc_sequencer. The stimulus process plays memory and
// datapath; a reference model computes the PC each fetch should use and the
// state each halt should leave, pushing those into queues. A monitor pops and
// compares each time the DUT presents a new instruction or halts.
// Counters are checked too when PC_SEQ_STATS_EN is defined.
`timescale 1ns/1ps
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam int          ADDR_W   = 64;
  localparam int          INSTR_W  = 32;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] pc;
  logic        halted;
  logic        fault;
`ifdef PC_SEQ_STATS_EN
  logic [31:0] retiredCount;
  logic [31:0] takenCount;
`endif

  pc_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus_if ();

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus_if.master),
    .pc     (pc),
    .halted (halted),
    .fault  (fault)
`ifdef PC_SEQ_STATS_EN
    ,
    .retired_count (retiredCount),
    .taken_count   (takenCount)
`endif
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [31:0] retired;
    logic [31:0] taken;
  } fetch_rec_t;

  typedef struct {
    logic [63:0] pc;
    logic        fault;
    logic [31:0] retired;
    logic [31:0] taken;
  } halt_rec_t;

  fetch_rec_t fetchQ[$];
  halt_rec_t  haltQ[$];

  // Reference model state
  logic [63:0] modelPc;
  logic [31:0] modelRetired;
  logic [31:0] modelTaken;
  bit          modelHalted;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: timed out waiting for DUT", name);
  endtask

  // Drive all datapath/memory inputs for one cycle and return at the next
  // falling edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic done, input logic [1:0] src,
                               input logic [63:0] off, input logic [63:0] alu);
    bus_if.imem_ack      = ack;
    bus_if.imem_rdata    = rdata;
    bus_if.exec_done     = done;
    bus_if.branch_src    = src;
    bus_if.branch_offset = off;
    bus_if.alu_result    = alu;
    @(negedge clk);
  endtask

  task automatic quiesce();
    bus_if.imem_ack  = 1'b0;
    bus_if.exec_done = 1'b0;
  endtask

  function automatic logic [31:0] satInc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Reset asserted between clock edges; outputs must clear with no edge.
  task automatic applyReset();
    #2 reset = 1'b1;
    #1;
    checkOutput("reset imem_req", 64'(bus_if.imem_req), 64'h0);
    checkOutput("reset instr_valid", 64'(bus_if.instr_valid), 64'h0);
    checkOutput("reset pc", pc, RESET_PC);
    checkOutput("reset imem_addr", bus_if.imem_addr, RESET_PC);
    checkOutput("reset halted", 64'(halted), 64'h0);
    checkOutput("reset fault", 64'(fault), 64'h0);
    checkOutput("reset instr", 64'(bus_if.instr), 64'h0);
`ifdef PC_SEQ_STATS_EN
    checkOutput("reset retired_count", 64'(retiredCount), 64'h0);
    checkOutput("reset taken_count", 64'(takenCount), 64'h0);
`endif
    checkOutput("unconsumed fetch records", 64'(fetchQ.size()), 64'h0);
    checkOutput("unconsumed halt records", 64'(haltQ.size()), 64'h0);
    fetchQ.delete();
    haltQ.delete();
    modelPc      = RESET_PC;
    modelRetired = '0;
    modelTaken   = '0;
    modelHalted  = 1'b0;
    quiesce();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.imem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    reportTimeout("fetch request");
  endtask

  // Answer a fetch after 'delay' wait cycles; during the wait a stray
  // exec_done with a random branch selection is presented and must be ignored.
  task automatic fetchInstr(input logic [31:0] rdata, input int delay,
                            output bit ok);
    fetch_rec_t rec;
    waitReq(ok);
    if (!ok) return;
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b0, $urandom, 1'b1, 2'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom});
    end
    rec.instr   = rdata;
    rec.pc      = modelPc;
    rec.retired = modelRetired;
    rec.taken   = modelTaken;
    fetchQ.push_back(rec);
    applyStimulus(1'b1, rdata, 1'b0, 2'b00, 64'h0, 64'h0);
    quiesce();
  endtask

  // Complete execution after 'delay' cycles; during the wait stray imem_ack
  // pulses with garbage data are presented and must be ignored.
  task automatic execInstr(input logic [1:0] src, input logic [63:0] off,
                           input logic [63:0] alu, input int delay);
    halt_rec_t hrec;
    bit        isFault;
    for (int i = 0; i < delay; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, 2'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom});
    end
    isFault      = (src == 2'b10) && (alu[1:0] != 2'b00);
    modelRetired = satInc(modelRetired);
    if (src == 2'b11 || isFault) begin
      modelHalted   = 1'b1;
      hrec.pc       = modelPc;
      hrec.fault    = isFault;
      hrec.retired  = modelRetired;
      hrec.taken    = modelTaken;
      haltQ.push_back(hrec);
    end else begin
      if (src == 2'b00) modelPc = modelPc + 64'd4;
      else if (src == 2'b01) modelPc = modelPc + off;
      else modelPc = alu;
      if (src != 2'b00) modelTaken = satInc(modelTaken);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, src, off, alu);
    quiesce();
    if (modelHalted) begin
      holdCheck();
    end else begin
      checkOutput("imem_req after exec", 64'(bus_if.imem_req), 64'h1);
      checkOutput("instr_valid after exec", 64'(bus_if.instr_valid), 64'h0);
    end
  endtask

  // HALT must hold the PC and ignore a start pulse.
  task automatic holdCheck();
    for (int i = 0; i < 12; i++) begin
      start = (i == 3);
      @(negedge clk);
      start = 1'b0;
      checkOutput("halt imem_req", 64'(bus_if.imem_req), 64'h0);
      checkOutput("halt pc", pc, modelPc);
      checkOutput("halt halted", 64'(halted), 64'h1);
    end
  endtask

  // Scoreboard monitor
  logic prevValid = 1'b0;
  logic prevHalted = 1'b0;

  always @(negedge clk) begin
    fetch_rec_t f;
    halt_rec_t  h;
    if (!reset) begin
      if (bus_if.instr_valid && !prevValid) begin
        if (fetchQ.size() == 0) begin
          reportTimeout("unexpected instr_valid (no fetch record)");
        end else begin
          f = fetchQ.pop_front();
          checkOutput("fetched instr", 64'(bus_if.instr), 64'(f.instr));
          checkOutput("fetch pc", pc, f.pc);
          checkOutput("fetch imem_addr", bus_if.imem_addr, f.pc);
          checkOutput("exec imem_req", 64'(bus_if.imem_req), 64'h0);
`ifdef PC_SEQ_STATS_EN
          checkOutput("fetch retired_count", 64'(retiredCount), 64'(f.retired));
          checkOutput("fetch taken_count", 64'(takenCount), 64'(f.taken));
`endif
        end
      end
      if (halted && !prevHalted) begin
        if (haltQ.size() == 0) begin
          reportTimeout("unexpected halt (no halt record)");
        end else begin
          h = haltQ.pop_front();
          checkOutput("halt record pc", pc, h.pc);
          checkOutput("halt record fault", 64'(fault), 64'(h.fault));
          checkOutput("halt record instr_valid", 64'(bus_if.instr_valid), 64'h0);
`ifdef PC_SEQ_STATS_EN
          checkOutput("halt retired_count", 64'(retiredCount), 64'(h.retired));
          checkOutput("halt taken_count", 64'(takenCount), 64'(h.taken));
`endif
        end
      end
    end
    prevValid  = bus_if.instr_valid;
    prevHalted = halted;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          ok;
    logic [1:0]  src;
    logic [63:0] off;
    logic [63:0] alu;
    int          r;

    quiesce();
    bus_if.imem_rdata    = '0;
    bus_if.branch_src    = '0;
    bus_if.branch_offset = '0;
    bus_if.alu_result    = '0;
    @(negedge clk);

    // Directed: basic fetch, wrap-free branches, PC wrap, hold
    applyReset();
    pulseStart();
    fetchInstr(32'h9100_0421, 2, ok);
    execInstr(BRANCH_SRC_SEQ, 64'h0, 64'h0, 0);
    fetchInstr($urandom, 0, ok);
    execInstr(BRANCH_SRC_ALU, 64'h0, 64'h100, 1);
    fetchInstr($urandom, 1, ok);
    execInstr(BRANCH_SRC_REL, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 0);
    fetchInstr($urandom, 0, ok);
    execInstr(BRANCH_SRC_ALU, 64'h0, 64'h2000, 2);
    fetchInstr($urandom, 0, ok);
    execInstr(BRANCH_SRC_ALU, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    fetchInstr($urandom, 3, ok);
    execInstr(BRANCH_SRC_SEQ, 64'h0, 64'h0, 0);
    fetchInstr($urandom, 0, ok);
    execInstr(BRANCH_SRC_HOLD, 64'h0, 64'h0, 1);

    // Directed: misaligned register target faults
    applyReset();
    pulseStart();
    fetchInstr($urandom, 0, ok);
    execInstr(BRANCH_SRC_ALU, 64'h0, 64'h2002, 0);

    // Directed: asynchronous reset while fetching, then idle until start
    applyReset();
    pulseStart();
    waitReq(ok);
    applyReset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle imem_req", 64'(bus_if.imem_req), 64'h0);
      checkOutput("idle pc", pc, RESET_PC);
    end
    pulseStart();
    fetchInstr($urandom, 0, ok);
    execInstr(BRANCH_SRC_HOLD, 64'h0, 64'h0, 0);

    // Randomized programs
    for (int run = 0; run < 6; run++) begin
      applyReset();
      pulseStart();
      for (int k = 0; k < 25 && !modelHalted; k++) begin
        fetchInstr($urandom, $urandom_range(0, 3), ok);
        if (!ok) break;
        r   = $urandom_range(0, 15);
        off = {$urandom, $urandom};
        off[1:0] = 2'b00;
        alu = {$urandom, $urandom};
        alu[1:0] = 2'b00;
        if (r <= 5) src = BRANCH_SRC_SEQ;
        else if (r <= 9) src = BRANCH_SRC_REL;
        else if (r <= 14) src = BRANCH_SRC_ALU;
        else src = BRANCH_SRC_HOLD;
        if (r == 14 && $urandom_range(0, 1) == 1) alu[1:0] = 2'($urandom_range(1, 3));
        execInstr(src, off, alu, $urandom_range(0, 3));
      end
    end

    applyReset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
